// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached burst RAM: command encodings and FSM states.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } state_e;

endpackage

// File: rtl/spi_ram_burst_if.sv
// Word-level bus between the SPI slave shifter (master) and the burst RAM (slave).
interface spi_ram_burst_if #(
    parameter int unsigned DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W+1:0] din;
    logic              rx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              tx_ready;
    logic              err;

    modport master (output rx_valid, din, tx_ready,
                    input  rx_ready, dout, tx_valid, err);

    modport slave  (input  rx_valid, din, tx_ready,
                    output rx_ready, dout, tx_valid, err);
endinterface

// File: rtl/spi_ram_core.sv
// Single-port storage array: synchronous write, registered read.
module spi_ram_core #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Write and registered read share the one address port; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder, pointers, read FSM and handshake in front of spi_ram_core.
// Optional build macro: SPI_RAM_AUTOINC_EN enables pointer auto-increment (burst access).
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_ram_burst_if.slave    bus
);
    localparam int unsigned LAST_ADDR = MEM_DEPTH - 1;

    state_e            state;
    state_e            state_next;
    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr_ld;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] dout_q;
    logic              rx_ready_q;
    logic              tx_valid_q;
    logic              err_q;
    logic              accept_c;
    logic              xfer_c;
    logic              in_range_c;

    assign cmd        = cmd_e'(bus.din[DATA_W+1:DATA_W]);
    assign payload    = bus.din[DATA_W-1:0];
    assign addr_ld    = payload[ADDR_W-1:0];
    assign accept_c   = bus.rx_valid & rx_ready_q;
    assign xfer_c     = tx_valid_q & bus.tx_ready;
    assign in_range_c = 32'(addr_ld) < MEM_DEPTH;

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.dout     = dout_q;
    assign bus.err      = err_q;

`ifdef SPI_RAM_AUTOINC_EN
    // Next pointer with wrap at the top of the populated array.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
        return (ptr == ADDR_W'(LAST_ADDR)) ? '0 : ADDR_W'(ptr + 1'b1);
    endfunction
`endif

    spi_ram_core #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (accept_c && (cmd == CMD_WR_DATA)),
        .re    (state == FETCH),
        .addr  ((state == FETCH) ? rd_ptr : wr_ptr),
        .wdata (payload),
        .rdata (rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a read command walks IDLE -> FETCH -> PRESENT, back on transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c && (cmd == CMD_RD_DATA)) state_next = FETCH;
            FETCH:   state_next = PRESENT;
            PRESENT: if (xfer_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pointer loads with range check; out-of-range loads leave the pointer and set sticky err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept_c) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        if (in_range_c) wr_ptr <= addr_ld;
                        else            err_q  <= 1'b1;
                    end
                    CMD_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                        wr_ptr <= ptr_inc(wr_ptr);
`endif
                    end
                    CMD_RD_ADDR: begin
                        if (in_range_c) rd_ptr <= addr_ld;
                        else            err_q  <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                    end
                endcase
            end
`ifdef SPI_RAM_AUTOINC_EN
            if (state == FETCH) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
`endif
        end
    end

    // Handshake outputs: dout loads on the first PRESENT cycle and holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            rx_ready_q <= (state_next == IDLE);
            if ((state == PRESENT) && !tx_valid_q) begin
                dout_q     <= rdata;
                tx_valid_q <= 1'b1;
            end else if (xfer_c) begin
                tx_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst (256-word instance plus a 200-word instance for range errors).
module tb_spi_ram_burst;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] payload;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    spi_ram_burst_if #(.DATA_W(8)) bus_a ();
    spi_ram_burst_if #(.DATA_W(8)) bus_b ();

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command word and hold it until the DUT accepts it.
    task automatic send(input bit b, input logic [1:0] cmd, input logic [7:0] pl);
        int n = 0;
        if (!b) begin
            bus_a.rx_valid = 1'b1;
            bus_a.din      = {cmd, pl};
            while (bus_a.rx_ready !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
        end else begin
            bus_b.rx_valid = 1'b1;
            bus_b.din      = {cmd, pl};
            while (bus_b.rx_ready !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
        end
        if (n >= 30) chk("send_timeout", 32'(n), 32'd0);
        tick();
        bus_a.rx_valid = 1'b0;
        bus_b.rx_valid = 1'b0;
    endtask

    task automatic add(input logic [1:0] c, input logic [7:0] p, input logic [7:0] e);
        vec_t v;
        v.cmd = c;
        v.payload = p;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: compare dout against the oldest expected word on each transfer.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus_a.tx_valid === 1'b1 && bus_a.tx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(bus_a.dout), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        rst_n = 1'b0;
        bus_a.rx_valid = 1'b0; bus_a.din = '0; bus_a.tx_ready = 1'b1;
        bus_b.rx_valid = 1'b0; bus_b.din = '0; bus_b.tx_ready = 1'b1;
        #3;
        chk("rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
        chk("rst_dout", 32'(bus_a.dout), 32'd0);
        chk("rst_err", 32'(bus_a.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rx_ready_after_rst_a", 32'(bus_a.rx_ready), 32'd1);
        chk("rx_ready_after_rst_b", 32'(bus_b.rx_ready), 32'd1);

        // Single write/read with the consumer stalling for five cycles.
        bus_a.tx_ready = 1'b0;
        send(0, 2'b00, 8'h10);
        send(0, 2'b01, 8'hA5);
        send(0, 2'b10, 8'h10);
        send(0, 2'b11, 8'h00);
        chk("lat_e0_tx_valid", 32'(bus_a.tx_valid), 32'd0);
        tick();
        chk("lat_e1_tx_valid", 32'(bus_a.tx_valid), 32'd0);
        tick();
        chk("lat_e2_tx_valid", 32'(bus_a.tx_valid), 32'd1);
        chk("lat_e2_dout", 32'(bus_a.dout), 32'hA5);
        chk("present_rx_ready", 32'(bus_a.rx_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_tx_valid", 32'(bus_a.tx_valid), 32'd1);
            chk("hold_dout", 32'(bus_a.dout), 32'hA5);
        end
        exp_q.push_back(8'hA5);
        bus_a.tx_ready = 1'b1;
        tick();
        chk("post_xfer_tx_valid", 32'(bus_a.tx_valid), 32'd0);
        chk("post_xfer_rx_ready", 32'(bus_a.rx_ready), 32'd1);
        chk("post_xfer_dout_hold", 32'(bus_a.dout), 32'hA5);
        chk("scoreboard_after_hold", 32'(exp_q.size()), 32'd0);

        // Burst write/read across the top of memory, then scattered addresses.
        add(2'b00, 8'hFE, 8'h00);
        add(2'b01, 8'h11, 8'h00);
        add(2'b01, 8'h22, 8'h00);
        add(2'b01, 8'h33, 8'h00);
        add(2'b10, 8'hFE, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
        add(2'b11, 8'h00, 8'h11);
        add(2'b11, 8'h00, 8'h22);
        add(2'b11, 8'h00, 8'h33);
`else
        add(2'b11, 8'h00, 8'h33);
        add(2'b11, 8'h00, 8'h33);
        add(2'b11, 8'h00, 8'h33);
`endif
        add(2'b00, 8'h05, 8'h00);
        add(2'b01, 8'h3C, 8'h00);
        add(2'b00, 8'h06, 8'h00);
        add(2'b01, 8'hC3, 8'h00);
        add(2'b10, 8'h05, 8'h00);
        add(2'b11, 8'h00, 8'h3C);
        add(2'b10, 8'h06, 8'h00);
        add(2'b11, 8'h00, 8'hC3);
        add(2'b10, 8'h10, 8'h00);
        add(2'b11, 8'h00, 8'hA5);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].cmd == 2'b11) exp_q.push_back(vecs[i].exp);
            send(0, vecs[i].cmd, vecs[i].payload);
        end
        drain();
        chk("err_a_in_range", 32'(bus_a.err), 32'd0);

        // Command offered during FETCH/PRESENT must wait for the transfer.
        bus_a.tx_ready = 1'b0;
        send(0, 2'b10, 8'h10);
        exp_q.push_back(8'hA5);
        send(0, 2'b11, 8'h00);
        bus_a.rx_valid = 1'b1;
        bus_a.din = {2'b00, 8'h20};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_rx_ready", 32'(bus_a.rx_ready), 32'd0);
        end
        bus_a.tx_ready = 1'b1;
        tick();
        chk("bp_xfer_tx_valid", 32'(bus_a.tx_valid), 32'd0);
        chk("bp_xfer_rx_ready", 32'(bus_a.rx_ready), 32'd1);
        tick();
        bus_a.rx_valid = 1'b0;
        send(0, 2'b01, 8'h5A);
        send(0, 2'b10, 8'h20);
        exp_q.push_back(8'h5A);
        send(0, 2'b11, 8'h00);
        drain();

        // Out-of-range address loads on the 200-word instance.
        send(1, 2'b00, 8'hC8);
        chk("range_err_set", 32'(bus_b.err), 32'd1);
        send(1, 2'b01, 8'h77);
        send(1, 2'b10, 8'h00);
        send(1, 2'b11, 8'h00);
        n = 0;
        while (bus_b.tx_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("range_rd_valid", 32'(bus_b.tx_valid), 32'd1);
        chk("range_wr_ptr_kept", 32'(bus_b.dout), 32'h77);
        tick();
        send(1, 2'b10, 8'hC9);
        chk("range_err_sticky_rd", 32'(bus_b.err), 32'd1);
        send(1, 2'b00, 8'h05);
        chk("range_err_sticky_ok", 32'(bus_b.err), 32'd1);

        // Reset asserted while a read is being presented.
        bus_a.tx_ready = 1'b0;
        send(0, 2'b10, 8'h10);
        send(0, 2'b11, 8'h00);
        tick();
        tick();
        chk("pre_rst_tx_valid", 32'(bus_a.tx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
        chk("mid_rst_dout", 32'(bus_a.dout), 32'd0);
        chk("mid_rst_err_a", 32'(bus_a.err), 32'd0);
        chk("mid_rst_err_b", 32'(bus_b.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.tx_ready = 1'b1;
        tick();
        chk("post_rst_rx_ready", 32'(bus_a.rx_ready), 32'd1);
        send(0, 2'b10, 8'h10);
        exp_q.push_back(8'hA5);
        send(0, 2'b11, 8'h00);
        send(0, 2'b01, 8'h66);
        send(0, 2'b10, 8'h00);
        exp_q.push_back(8'h66);
        send(0, 2'b11, 8'h00);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
